mgia_line_fetcher: RTL and testbench

Parametrised successor to the MGIA video fetcher: per scan line, burst-reads a programmable window of framebuffer words over the Wishbone-style RAM port and writes them into the line buffer. New over the first generation:
- runtime framebuffer base and line stride, latched per frame;
- line-doubling mode;
- bus-error tolerance;
- underrun reporting when the fetch window closes early.

It sits between the timebase (VSYNC/VFEN) and the line buffers, on the 25 MHz pixel clock.

---
 rtl/mgia_pkg.sv | 14 +
 rtl/mgia_fetch_addr_gen.sv | 42 ++++
 rtl/mgia_line_fetcher.sv | 115 +++++++++++
 tb/tb_mgia_line_fetcher.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mgia_pkg.sv
// Shared types and default sizing for the MGIA line fetcher.
package mgia_pkg;

    localparam int DEF_DAT_W          = 16;
    localparam int DEF_ADR_W          = 13;
    localparam int DEF_LB_ADR_W       = 6;
    localparam int DEF_WORDS_PER_LINE = 40;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

endpackage

// File: rtl/mgia_fetch_addr_gen.sv
// Per-frame line address generator: holds the current line start, stride,
// line-double flag and the doubling parity.
module mgia_fetch_addr_gen
    import mgia_pkg::*;
#(
    parameter int ADR_W = DEF_ADR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             advance,
    input  logic [ADR_W-1:0] base,
    input  logic [ADR_W-1:0] stride,
    input  logic             dbl,
    output logic [ADR_W-1:0] line_ptr
);

    logic [ADR_W-1:0] stride_q;
    logic             dbl_q;
    logic             parity;

    // A frame-start reload wins over a line-end advance in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_ptr <= '0;
            stride_q <= '0;
            dbl_q    <= 1'b0;
            parity   <= 1'b0;
        end else if (load) begin
            line_ptr <= base;
            stride_q <= stride;
            dbl_q    <= dbl;
            parity   <= 1'b0;
        end else if (advance) begin
            if (!dbl_q || parity) begin
                line_ptr <= line_ptr + stride_q;
            end
            parity <= ~parity;
        end
    end

endmodule

// File: rtl/mgia_line_fetcher.sv
// Per-line framebuffer fetcher: burst-reads a window of RAM words on each
// fetch-window rising edge and writes them into the line buffer.
module mgia_line_fetcher
    import mgia_pkg::*;
#(
    parameter int DAT_W          = DEF_DAT_W,
    parameter int ADR_W          = DEF_ADR_W,
    parameter int LB_ADR_W       = DEF_LB_ADR_W,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
    input  logic                CLK_I,
    input  logic                RST_I,
    input  logic                VSYNC_I,
    input  logic                VFEN_I,
    input  logic [ADR_W-1:0]    BASE_I,
    input  logic [ADR_W-1:0]    STRIDE_I,
    input  logic                DBL_I,
    output logic [ADR_W-1:0]    RAM_ADR_O,
    output logic                RAM_CYC_O,
    output logic                RAM_STB_O,
    input  logic                RAM_ACK_I,
    input  logic                RAM_ERR_I,
    input  logic [DAT_W-1:0]    RAM_DAT_I,
    output logic [LB_ADR_W-1:0] LB_ADR_O,
    output logic [DAT_W-1:0]    LB_DAT_O,
    output logic                LB_WE_O,
    output logic                BUSY_O,
    output logic                UNDERRUN_O
);

    state_t              state, state_nxt;
    logic                vsync_q, vfen_q;
    logic                frame_start, line_start;
    logic                accept, last_word;
    logic                advance, underrun_nxt;
    logic [LB_ADR_W-1:0] word_ctr;
    logic [ADR_W-1:0]    line_ptr;

    assign frame_start = vsync_q & ~VSYNC_I;
    assign line_start  = ~vfen_q & VFEN_I;
    assign accept      = (state == FETCH) & (RAM_ACK_I | RAM_ERR_I);
    assign last_word   = (word_ctr == LB_ADR_W'(WORDS_PER_LINE - 1));

    mgia_fetch_addr_gen #(
        .ADR_W (ADR_W)
    ) u_addr_gen (
        .clk      (CLK_I),
        .rst      (RST_I),
        .load     (frame_start),
        .advance  (advance),
        .base     (BASE_I),
        .stride   (STRIDE_I),
        .dbl      (DBL_I),
        .line_ptr (line_ptr)
    );

    // Completion of the last word outranks an abort in the same cycle; a
    // frame start outranks both and never flags an underrun.
    always_comb begin
        state_nxt    = state;
        advance      = 1'b0;
        underrun_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (line_start) state_nxt = FETCH;
            end
            FETCH: begin
                if (frame_start) begin
                    state_nxt = IDLE;
                end else if (accept && last_word) begin
                    state_nxt = IDLE;
                    advance   = 1'b1;
                end else if (!VFEN_I) begin
                    state_nxt    = IDLE;
                    advance      = 1'b1;
                    underrun_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state      <= IDLE;
            vsync_q    <= 1'b0;
            vfen_q     <= 1'b0;
            word_ctr   <= '0;
            UNDERRUN_O <= 1'b0;
            LB_WE_O    <= 1'b0;
            LB_ADR_O   <= '0;
            LB_DAT_O   <= '0;
        end else begin
            state      <= state_nxt;
            vsync_q    <= VSYNC_I;
            vfen_q     <= VFEN_I;
            UNDERRUN_O <= underrun_nxt;
            if (state == IDLE && line_start) begin
                word_ctr <= '0;
            end else if (accept) begin
                word_ctr <= word_ctr + 1'b1;
            end
            // Error responses land in the line buffer as zero.
            LB_WE_O  <= accept;
            LB_ADR_O <= word_ctr;
            LB_DAT_O <= RAM_ERR_I ? '0 : RAM_DAT_I;
        end
    end

    assign RAM_CYC_O = (state == FETCH);
    assign RAM_STB_O = (state == FETCH);
    assign BUSY_O    = (state == FETCH);
    assign RAM_ADR_O = line_ptr + ADR_W'(word_ctr);

endmodule

// File: tb/tb_mgia_line_fetcher.sv
// Directed bench for mgia_line_fetcher: zero-wait, wait-state, doubled,
// aborted, bus-error, wrapping and frame-restart line fetches.
module tb_mgia_line_fetcher;

    localparam int DAT_W    = 16;
    localparam int ADR_W    = 13;
    localparam int LB_ADR_W = 6;
    localparam int WPL      = 40;

    logic                clk;
    logic                rst;
    logic                vsync;
    logic                vfen;
    logic [ADR_W-1:0]    base;
    logic [ADR_W-1:0]    stride;
    logic                dbl;
    logic [ADR_W-1:0]    ram_adr;
    logic                ram_cyc;
    logic                ram_stb;
    logic                ram_ack;
    logic                ram_err;
    logic [DAT_W-1:0]    ram_dat;
    logic [LB_ADR_W-1:0] lb_adr;
    logic [DAT_W-1:0]    lb_dat;
    logic                lb_we;
    logic                busy;
    logic                underrun;

    mgia_line_fetcher #(
        .DAT_W          (DAT_W),
        .ADR_W          (ADR_W),
        .LB_ADR_W       (LB_ADR_W),
        .WORDS_PER_LINE (WPL)
    ) dut (
        .CLK_I      (clk),
        .RST_I      (rst),
        .VSYNC_I    (vsync),
        .VFEN_I     (vfen),
        .BASE_I     (base),
        .STRIDE_I   (stride),
        .DBL_I      (dbl),
        .RAM_ADR_O  (ram_adr),
        .RAM_CYC_O  (ram_cyc),
        .RAM_STB_O  (ram_stb),
        .RAM_ACK_I  (ram_ack),
        .RAM_ERR_I  (ram_err),
        .RAM_DAT_I  (ram_dat),
        .LB_ADR_O   (lb_adr),
        .LB_DAT_O   (lb_dat),
        .LB_WE_O    (lb_we),
        .BUSY_O     (busy),
        .UNDERRUN_O (underrun)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    logic [DAT_W-1:0] lb_mem [64];
    bit               lb_seen[64];
    int               lb_writes;
    int               lb_dups;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DAT_W-1:0] dat_of(input logic [ADR_W-1:0] a);
        return {3'b101, a};
    endfunction

    // Advance one cycle, sample #1 after the edge and log any line-buffer write.
    task automatic tick();
        @(posedge clk);
        #1;
        if (lb_we === 1'b1) begin
            if (lb_seen[lb_adr]) lb_dups++;
            lb_seen[lb_adr] = 1'b1;
            lb_mem[lb_adr]  = lb_dat;
            lb_writes++;
        end
    endtask

    // Frame start, then scramble the frame inputs so any late sampling shows.
    task automatic frame(input logic [ADR_W-1:0] b, input logic [ADR_W-1:0] s, input logic d);
        base   = b;
        stride = s;
        dbl    = d;
        vsync  = 1'b0;
        tick();
        vsync  = 1'b1;
        base   = 13'h0AAA;
        stride = 13'd3;
        dbl    = ~d;
        tick();
    endtask

    // mode 0: full line; 1: VFEN drops after n_words; 2: frame start on word n_words-1
    task automatic run_line(input string tag, input logic [ADR_W-1:0] start, input int period,
                            input int err_word, input bit err_ack, input int n_words,
                            input int mode, input logic [ADR_W-1:0] new_base);
        logic [ADR_W-1:0] a;
        logic [DAT_W-1:0] e;
        int words, cyc, guard;
        for (int i = 0; i < 64; i++) begin
            lb_seen[i] = 1'b0;
            lb_mem[i]  = 'x;
        end
        lb_writes = 0;
        lb_dups   = 0;
        words     = 0;
        cyc       = 0;
        guard     = 0;
        vfen      = 1'b1;
        while (words < n_words && guard < 400) begin
            tick();
            guard++;
            a = start + ADR_W'(words);
            check({tag, ".cyc"}, 32'(ram_cyc), 32'd1);
            check({tag, ".stb"}, 32'(ram_stb), 32'd1);
            check({tag, ".busy"}, 32'(busy), 32'd1);
            check({tag, ".adr"}, 32'(ram_adr), 32'(a));
            check({tag, ".urun_low"}, 32'(underrun), 32'd0);
            ram_ack = 1'b0;
            ram_err = 1'b0;
            ram_dat = 16'hDEAD;
            if ((cyc % period) == period - 1) begin
                if (words == err_word) begin
                    ram_err = 1'b1;
                    ram_ack = err_ack;
                end else begin
                    ram_ack = 1'b1;
                end
                ram_dat = dat_of(a);
                words++;
                if (mode == 2 && words == n_words) begin
                    vsync  = 1'b0;
                    base   = new_base;
                    stride = 13'd40;
                    dbl    = 1'b0;
                end
            end
            cyc++;
        end
        check({tag, ".timeout"}, 32'(words), 32'(n_words));
        tick();
        ram_ack = 1'b0;
        ram_err = 1'b0;
        ram_dat = 16'hDEAD;
        if (mode == 1) begin
            check({tag, ".cyc_pre_abort"}, 32'(ram_cyc), 32'd1);
            vfen = 1'b0;
            tick();
            check({tag, ".cyc_abort"}, 32'(ram_cyc), 32'd0);
            check({tag, ".busy_abort"}, 32'(busy), 32'd0);
            check({tag, ".urun_pulse"}, 32'(underrun), 32'd1);
            tick();
            check({tag, ".urun_end"}, 32'(underrun), 32'd0);
        end else begin
            check({tag, ".cyc_end"}, 32'(ram_cyc), 32'd0);
            check({tag, ".stb_end"}, 32'(ram_stb), 32'd0);
            check({tag, ".busy_end"}, 32'(busy), 32'd0);
            check({tag, ".urun_end"}, 32'(underrun), 32'd0);
            vfen  = 1'b0;
            vsync = 1'b1;
            tick();
            check({tag, ".urun_after"}, 32'(underrun), 32'd0);
        end
        check({tag, ".lb_writes"}, 32'(lb_writes), 32'(n_words));
        check({tag, ".lb_dups"}, 32'(lb_dups), 32'd0);
        for (int i = 0; i < n_words; i++) begin
            e = (i == err_word) ? '0 : dat_of(start + ADR_W'(i));
            check({tag, ".lb_dat"}, 32'(lb_mem[i]), 32'(e));
        end
    endtask

    initial begin
        rst     = 1'b1;
        vsync   = 1'b1;
        vfen    = 1'b0;
        base    = '0;
        stride  = '0;
        dbl     = 1'b0;
        ram_ack = 1'b0;
        ram_err = 1'b0;
        ram_dat = '0;
        tick();
        tick();
        check("rst.cyc", 32'(ram_cyc), 32'd0);
        check("rst.stb", 32'(ram_stb), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.adr", 32'(ram_adr), 32'd0);
        check("rst.lb_we", 32'(lb_we), 32'd0);
        check("rst.lb_adr", 32'(lb_adr), 32'd0);
        check("rst.lb_dat", 32'(lb_dat), 32'd0);
        check("rst.urun", 32'(underrun), 32'd0);
        rst = 1'b0;
        tick();
        tick();
        check("idle.cyc", 32'(ram_cyc), 32'd0);

        // three plain lines
        frame(13'h0100, 13'd40, 1'b0);
        run_line("plain0", 13'h0100, 1, -1, 1'b0, WPL, 0, '0);
        run_line("plain1", 13'h0128, 1, -1, 1'b0, WPL, 0, '0);
        run_line("plain2", 13'h0150, 1, -1, 1'b0, WPL, 0, '0);

        // line doubling
        frame(13'h0100, 13'd40, 1'b1);
        run_line("dbl0", 13'h0100, 1, -1, 1'b0, WPL, 0, '0);
        run_line("dbl1", 13'h0100, 1, -1, 1'b0, WPL, 0, '0);
        run_line("dbl2", 13'h0128, 1, -1, 1'b0, WPL, 0, '0);
        run_line("dbl3", 13'h0128, 1, -1, 1'b0, WPL, 0, '0);

        // wait states, abort, bus error
        frame(13'h0100, 13'd40, 1'b0);
        run_line("wait3", 13'h0100, 3, -1, 1'b0, WPL, 0, '0);
        run_line("abort", 13'h0128, 1, -1, 1'b0, 10, 1, '0);
        run_line("err5", 13'h0150, 1, 5, 1'b0, WPL, 0, '0);

        // address wrap, ERR with ACK, frame restart mid-fetch
        frame(13'h1FF0, 13'd40, 1'b0);
        run_line("wrap", 13'h1FF0, 1, 7, 1'b1, WPL, 0, '0);
        run_line("restart", 13'h0018, 1, -1, 1'b0, 6, 2, 13'h0200);
        run_line("newbase", 13'h0200, 2, -1, 1'b0, WPL, 0, '0);

        // reset in the middle of a fetch
        vfen = 1'b1;
        tick();
        ram_ack = 1'b1;
        ram_dat = 16'h1234;
        tick();
        check("rstmid.cyc_pre", 32'(ram_cyc), 32'd1);
        rst = 1'b1;
        tick();
        check("rstmid.cyc", 32'(ram_cyc), 32'd0);
        check("rstmid.busy", 32'(busy), 32'd0);
        check("rstmid.lb_we", 32'(lb_we), 32'd0);
        check("rstmid.adr", 32'(ram_adr), 32'd0);
        ram_ack = 1'b0;
        rst     = 1'b0;
        vfen    = 1'b0;
        tick();
        check("rstmid.lb_we_after", 32'(lb_we), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
